atto_cfg_loader: RTL
====================

Name: atto_cfg_loader

Overview:
Configuration sequencer for the atto FPGA fabric. It accepts configuration bytes from the 8-bit bidirectional pin bank using a host-driven strobe, pulses them into the fabric config shift chain, and counts them against the chain length. It holds the fabric disabled until a complete, valid image has loaded. It sits between the top-level pin wrapper and the fabric unit's config port.

Parameters:
CHAIN_BYTES, 16, number of config bytes in one full fabric image
SYNC_STAGES, 2, flop depth of the input synchronisers (min 2)
CNT_W, $clog2(CHAIN_BYTES+1), derived width of byte_count (localparam)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
cfg_data  input  8  config byte from host, asynchronous to clk
cfg_strobe  input  1  host byte strobe, asynchronous; rising edge = byte present
cfg_start  input  1  host start, asynchronous; rising edge = begin new image
chain_data  output  8  byte presented to fabric config chain
chain_shift  output  1  one-cycle pulse: fabric shifts chain_data in
fabric_en  output  1  fabric run enable; 0 forces fabric outputs inactive
cfg_done  output  1  image loaded and accepted
cfg_error  output  1  image rejected (checksum mismatch)
byte_count  output  CNT_W  bytes accepted in current image

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs are 0, state is IDLE, and all synchroniser flops are 0. Reset mid-load returns to IDLE. Fabric chain contents are not touched, but fabric_en stays 0 until a new image completes.
- Input capture: cfg_strobe and cfg_start each pass through SYNC_STAGES flops plus one edge flop, giving a one-cycle rising-edge pulse. cfg_data is delayed by the same SYNC_STAGES flops.
- Host hold rule: the host holds cfg_data stable from SYNC_STAGES+2 cycles before to SYNC_STAGES+2 cycles after the strobe rises.
- States: IDLE, LOAD, CHECK (only with the optional feature), RUN, ERR.
- Start edge in any state:
  - Go to LOAD.
  - Clear byte_count and the checksum accumulator.
  - Deassert fabric_en, cfg_done and cfg_error on the next edge.
- Strobe edge in LOAD:
  - chain_data is registered with the synchronised byte.
  - chain_shift is high for exactly 1 cycle.
  - byte_count increments.
  - Latency: a strobe first sampled high at edge N gives chain_shift high in the cycle after edge N+SYNC_STAGES+1.
- End of image: when byte_count reaches CHAIN_BYTES, go to RUN (or to CHECK with the feature). This transition happens in the same cycle as the final chain_shift.
- RUN: fabric_en=1 and cfg_done=1. Strobe edges are ignored: no shift, no count change.
- IDLE and ERR: strobe edges are ignored. In ERR, cfg_error=1 and fabric_en=0.
- Start and strobe edges in the same cycle: start wins, the byte is dropped, and no chain_shift occurs.
- byte_count never exceeds CHAIN_BYTES. It holds its final value in RUN and ERR.
- chain_data holds its last value between shifts.

Optional Feature:
Macro: ATTO_CFG_CHECKSUM_EN.
- Defined:
  - An 8-bit XOR accumulator covers all CHAIN_BYTES bytes.
  - After the last byte, the FSM enters CHECK and waits for one more strobe edge carrying the checksum byte. That byte is not shifted into the chain and is not counted.
  - Match: go to RUN. Mismatch: go to ERR.
  - A start edge during CHECK restarts LOAD.
- Undefined: there is no CHECK state and no accumulator, and cfg_error is tied to 0.

Decomposition:
- Package atto_cfg_pkg holds:
  - the state typedef (IDLE, LOAD, CHECK, RUN, ERR) with fixed binary encoding 0-4;
  - the default CHAIN_BYTES constant;
  - the checksum width constant (8).
- Sub-module atto_sync_edge provides a parameterised SYNC_STAGES synchroniser plus a rising-edge pulse. It is instantiated for cfg_strobe and cfg_start. The data path uses a plain delay line of the same depth.

Test Plan:
- Reset: rst_n low with random inputs -> all outputs 0. Release, then strobe 3 times with no start -> no chain_shift, byte_count=0.
- Full load: start, then bytes 0x01..0x10 (CHAIN_BYTES=16, feature off) -> 16 chain_shift pulses with chain_data 0x01..0x10 in order. Each pulse follows its strobe by SYNC_STAGES+1 edges. After the 16th, fabric_en=1, cfg_done=1, byte_count=16.
- Post-load strobes: 4 extra strobes in RUN -> no chain_shift, byte_count stays 16.
- Restart: start mid-load after 5 bytes -> byte_count=0 and fabric_en=0. A further 16 bytes then reach RUN.
- Simultaneous events: start and strobe edges aligned in LOAD -> no shift, byte_count=0. Separately, asynchronous reset after 7 bytes -> IDLE immediately, fabric_en stays 0.
- Checksum (ATTO_CFG_CHECKSUM_EN): bytes 0x01..0x10 then 0x10 (the XOR of 0x01..0x10) -> RUN. Same image with checksum 0x11 -> ERR with cfg_error=1 and fabric_en=0. A start edge then clears cfg_error.

Source files
------------

// File: rtl/atto_cfg_pkg.sv
// Shared types and constants for the atto fabric configuration loader.
package atto_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    localparam int unsigned CHAIN_BYTES_DEF = 16;
    localparam int unsigned CSUM_W          = 8;

endpackage

// File: rtl/atto_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, followed by a registered
// one-cycle rising-edge pulse.
module atto_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   last_q, last_d;
    logic                   pulse_q, pulse_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], async_in};
        last_d  = sync_q[SYNC_STAGES-1];
        pulse_d = sync_q[SYNC_STAGES-1] & ~last_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            last_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            last_q  <= last_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/atto_cfg_loader.sv
// Host-strobed config byte loader for the atto fabric config chain.
// Optional trailing XOR checksum byte enabled by ATTO_CFG_CHECKSUM_EN.
module atto_cfg_loader
    import atto_cfg_pkg::*;
#(
    parameter  int CHAIN_BYTES = CHAIN_BYTES_DEF,
    parameter  int SYNC_STAGES = 2,
    localparam int CNT_W       = $clog2(CHAIN_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       cfg_data,
    input  logic             cfg_strobe,
    input  logic             cfg_start,
    output logic [7:0]       chain_data,
    output logic             chain_shift,
    output logic             fabric_en,
    output logic             cfg_done,
    output logic             cfg_error,
    output logic [CNT_W-1:0] byte_count
);

    logic strobe_pulse, start_pulse;

    atto_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_strobe_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (cfg_strobe),
        .pulse    (strobe_pulse)
    );

    atto_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (cfg_start),
        .pulse    (start_pulse)
    );

    // Data follows the strobe through an equal-depth line; the host hold
    // window keeps it stable while the strobe edge is being qualified.
    logic [7:0] data_q [SYNC_STAGES];
    logic [7:0] data_d [SYNC_STAGES];
    logic [7:0] data_sync;

    always_comb begin
        data_d[0] = cfg_data;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            data_d[i] = data_q[i-1];
        end
    end

    // NOTE: the delay line is reset like the control synchronisers so the
    // loader comes up with no X on the datapath feeding chain_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign data_sync = data_q[SYNC_STAGES-1];

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       chain_data_q, chain_data_d;
    logic             shift_q, shift_d;
    logic             en_q, en_d;
    logic             done_q, done_d;
`ifdef ATTO_CFG_CHECKSUM_EN
    logic [CSUM_W-1:0] csum_q, csum_d;
    logic              err_q, err_d;
`endif

    // NOTE: every variable gets a default before the case so no latch can be
    // inferred on paths that do not assign it.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        chain_data_d = chain_data_q;
        shift_d      = 1'b0;
`ifdef ATTO_CFG_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        // A start edge dominates; a coincident strobe byte is dropped.
        if (start_pulse) begin
            state_d = ST_LOAD;
            count_d = '0;
`ifdef ATTO_CFG_CHECKSUM_EN
            csum_d  = '0;
`endif
        end else if (strobe_pulse) begin
            case (state_q)
                ST_LOAD: begin
                    chain_data_d = data_sync;
                    shift_d      = 1'b1;
                    count_d      = count_q + 1'b1;
`ifdef ATTO_CFG_CHECKSUM_EN
                    csum_d       = csum_q ^ data_sync;
                    if (count_q == CNT_W'(CHAIN_BYTES - 1)) state_d = ST_CHECK;
`else
                    if (count_q == CNT_W'(CHAIN_BYTES - 1)) state_d = ST_RUN;
`endif
                end
`ifdef ATTO_CFG_CHECKSUM_EN
                ST_CHECK: state_d = (data_sync == csum_q) ? ST_RUN : ST_ERR;
`endif
                default: ;
            endcase
        end
        en_d   = (state_d == ST_RUN);
        done_d = (state_d == ST_RUN);
`ifdef ATTO_CFG_CHECKSUM_EN
        err_d  = (state_d == ST_ERR);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            chain_data_q <= '0;
            shift_q      <= 1'b0;
            en_q         <= 1'b0;
            done_q       <= 1'b0;
`ifdef ATTO_CFG_CHECKSUM_EN
            csum_q       <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            chain_data_q <= chain_data_d;
            shift_q      <= shift_d;
            en_q         <= en_d;
            done_q       <= done_d;
`ifdef ATTO_CFG_CHECKSUM_EN
            csum_q       <= csum_d;
            err_q        <= err_d;
`endif
        end
    end

    assign chain_data  = chain_data_q;
    assign chain_shift = shift_q;
    assign fabric_en   = en_q;
    assign cfg_done    = done_q;
    assign byte_count  = count_q;
`ifdef ATTO_CFG_CHECKSUM_EN
    assign cfg_error   = err_q;
`else
    assign cfg_error   = 1'b0;
`endif

endmodule
